// File: rtl/elevador_scan.sv
// Single-car elevator controller with SCAN scheduling, latched requests,
// timed door with overload hold and a saturating passenger counter.
module elevador_scan #(
   parameter int unsigned N_ANDARES     = 8,
   parameter int unsigned FLOOR_W       = 3,
   parameter int unsigned TRAVEL_CYCLES = 4,
   parameter int unsigned DOOR_CYCLES   = 6,
   parameter int unsigned CAPACITY      = 10,
   parameter int unsigned CNT_W         = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_ANDARES-1:0] req,
   input  logic                 person_enter,
   input  logic                 person_exit,
   output logic                 motor_up,
   output logic                 motor_down,
   output logic                 door_open,
   output logic                 busy,
   output logic [FLOOR_W-1:0]   andar_atual,
   output logic [N_ANDARES-1:0] pending,
   output logic [CNT_W-1:0]     num_people,
   output logic                 overload
);

   localparam int unsigned NF = 2 ** FLOOR_W;
   localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
   localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP    = FLOOR_W'(N_ANDARES - 1);

   typedef enum logic [1:0] {
      IDLE,
      MOVING_UP,
      MOVING_DOWN,
      DOOR_OPEN
   } state_t;

   state_t             state, state_n;
   logic [FLOOR_W-1:0] floor_n, arrive;
   logic               dir_up, dir_n;
   logic [TW-1:0]      travel_cnt, travel_n;
   logic [DW-1:0]      door_cnt, door_n;
   logic [NF-1:0]      eff_x, clr;
   logic               here;

   function automatic logic any_above(input logic [NF-1:0] v, input logic [FLOOR_W-1:0] f);
      any_above = 1'b0;
      for (int unsigned i = 0; i < N_ANDARES; i++)
         if (v[i] && (i > 32'(f))) any_above = 1'b1;
   endfunction

   function automatic logic any_below(input logic [NF-1:0] v, input logic [FLOOR_W-1:0] f);
      any_below = 1'b0;
      for (int unsigned i = 0; i < N_ANDARES; i++)
         if (v[i] && (i < 32'(f))) any_below = 1'b1;
   endfunction

   // Departure rule shared by IDLE and a closing door: keep the current
   // direction while it has work, otherwise turn around, otherwise rest.
   function automatic state_t depart(input logic [NF-1:0] v, input logic [FLOOR_W-1:0] f,
                                     input logic d);
      logic up, dn;
      up = any_above(v, f);
      dn = any_below(v, f);
      if ((d && up) || (!d && !dn && up)) depart = MOVING_UP;
      else if (dn)                        depart = MOVING_DOWN;
      else                                depart = IDLE;
   endfunction

   always_comb begin
      eff_x = '0;
      eff_x[N_ANDARES-1:0] = pending | req;
   end

   assign here = eff_x[andar_atual];

   always_comb begin
      state_n  = state;
      floor_n  = andar_atual;
      dir_n    = dir_up;
      travel_n = travel_cnt;
      door_n   = door_cnt;
      clr      = '0;
      arrive   = andar_atual;
      case (state)
         IDLE, DOOR_OPEN: begin
            if (here) begin
               state_n          = DOOR_OPEN;
               clr[andar_atual] = 1'b1;
               door_n           = DOOR_LOAD;
            end else if (state == DOOR_OPEN && (door_cnt != '0 || overload)) begin
               if (door_cnt != '0) door_n = door_cnt - 1'b1;
            end else begin
               state_n = depart(eff_x, andar_atual, dir_up);
            end
         end
         MOVING_UP, MOVING_DOWN: begin
            if (travel_cnt != '0) begin
               travel_n = travel_cnt - 1'b1;
            end else begin
               travel_n = TRAVEL_LOAD;
               if (state == MOVING_UP) arrive = (andar_atual == TOP) ? andar_atual : andar_atual + 1'b1;
               else                    arrive = (andar_atual == '0) ? andar_atual : andar_atual - 1'b1;
               floor_n = arrive;
               if (eff_x[arrive]) begin
                  state_n     = DOOR_OPEN;
                  clr[arrive] = 1'b1;
                  door_n      = DOOR_LOAD;
               end else if (state == MOVING_UP) begin
                  if (any_above(eff_x, arrive))      state_n = MOVING_UP;
                  else if (any_below(eff_x, arrive)) state_n = MOVING_DOWN;
                  else                               state_n = IDLE;
               end else begin
                  if (any_below(eff_x, arrive))      state_n = MOVING_DOWN;
                  else if (any_above(eff_x, arrive)) state_n = MOVING_UP;
                  else                               state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (state_n == MOVING_UP)   dir_n = 1'b1;
      if (state_n == MOVING_DOWN) dir_n = 1'b0;
      if ((state_n == MOVING_UP || state_n == MOVING_DOWN) && state_n != state)
         travel_n = TRAVEL_LOAD;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         andar_atual <= '0;
         pending     <= '0;
         dir_up      <= 1'b1;
         travel_cnt  <= '0;
         door_cnt    <= '0;
      end else begin
         state       <= state_n;
         andar_atual <= floor_n;
         pending     <= eff_x[N_ANDARES-1:0] & ~clr[N_ANDARES-1:0];
         dir_up      <= dir_n;
         travel_cnt  <= travel_n;
         door_cnt    <= door_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         num_people <= '0;
      end else if (person_enter && !person_exit && num_people != '1) begin
         num_people <= num_people + 1'b1;
      end else if (person_exit && !person_enter && num_people != '0) begin
         num_people <= num_people - 1'b1;
      end
   end

   assign overload   = (32'(num_people) > CAPACITY);
   assign motor_up   = (state == MOVING_UP);
   assign motor_down = (state == MOVING_DOWN);
   assign door_open  = (state == DOOR_OPEN);
   assign busy       = (state != IDLE) || (pending != '0);

endmodule

// File: tb/tb_elevador_scan.sv
// Scenario bench for elevador_scan: expected door-service floors are queued
// when requests are issued and popped when the door actually opens.
module tb_elevador_scan;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] req;
   logic       person_enter, person_exit;
   logic       motor_up, motor_down, door_open, busy, overload;
   logic [2:0] andar_atual;
   logic [7:0] pending;
   logic [3:0] num_people;
   logic [19:0] outv;

   int checks = 0;
   int errors = 0;
   int sb_q[$];
   logic door_prev = 1'b0;

   elevador_scan #(
      .N_ANDARES(8), .FLOOR_W(3), .TRAVEL_CYCLES(4),
      .DOOR_CYCLES(6), .CAPACITY(10), .CNT_W(4)
   ) dut (
      .clk(clk), .reset(reset), .req(req),
      .person_enter(person_enter), .person_exit(person_exit),
      .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
      .busy(busy), .andar_atual(andar_atual), .pending(pending),
      .num_people(num_people), .overload(overload)
   );

   always #5 clk = ~clk;

   assign outv = {motor_up, motor_down, door_open, busy, andar_atual, pending, num_people, overload};

   // door-open monitor: each opening consumes one expected floor
   always begin
      int exp_f;
      @(posedge clk);
      #2;
      if (door_open && !door_prev) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL door_unexpected floor=%0d expected=none", andar_atual);
         end else begin
            exp_f = sb_q.pop_front();
            if (andar_atual !== 3'(exp_f)) begin
               errors++;
               $display("FAIL door_floor got=%0d exp=%0d", andar_atual, exp_f);
            end
         end
      end
      door_prev = door_open;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int max, output bit to);
      to = 1'b1;
      for (int i = 0; i < max; i++) begin
         tick();
         if (!busy) begin to = 1'b0; break; end
      end
   endtask

   task automatic wait_floor(input logic [2:0] f, input int max, output bit to);
      to = 1'b1;
      for (int i = 0; i < max; i++) begin
         tick();
         if (andar_atual == f) begin to = 1'b0; break; end
      end
   endtask

   task automatic wait_door_at(input logic [2:0] f, input int max, output bit to);
      to = 1'b1;
      for (int i = 0; i < max; i++) begin
         tick();
         if (door_open && andar_atual == f) begin to = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req = '0; person_enter = 1'b0; person_exit = 1'b0;
      tick(); tick();
      checks++;
      if (outv !== 20'h0) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", outv, 20'h0); end
      reset = 1'b0;
      tick(); tick();
      checks++;
      if (outv !== 20'h0) begin errors++; $display("FAIL idle_after_reset got=%h exp=%h", outv, 20'h0); end
   endtask

   task automatic test_travel_up();
      int n;
      req = 8'h20; tick(); req = '0;
      sb_q.push_back(5);
      checks++;
      if (motor_up !== 1'b1) begin errors++; $display("FAIL up_start motor_up=%b exp=1", motor_up); end
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i % 4 == 0) begin
            checks++;
            if (andar_atual !== 3'(i / 4)) begin
               errors++; $display("FAIL up_step cycle=%0d floor=%0d exp=%0d", i, andar_atual, i / 4);
            end
         end
      end
      checks++;
      if ({door_open, motor_up} !== 2'b10) begin
         errors++; $display("FAIL up_arrive door/motor=%b exp=10", {door_open, motor_up});
      end
      n = 1;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (door_open) n++;
         else break;
      end
      checks++;
      if (n != 6) begin errors++; $display("FAIL door_time got=%0d exp=6", n); end
      checks++;
      if ({busy, pending} !== 9'h0) begin
         errors++; $display("FAIL up_done busy=%b pending=%h exp=0/00", busy, pending);
      end
   endtask

   task automatic test_scan();
      bit to;
      req = 8'h08; tick(); req = '0;
      sb_q.push_back(3);
      wait_idle(60, to);
      checks++;
      if (to || andar_atual !== 3'd3) begin errors++; $display("FAIL scan_setup floor=%0d exp=3 timeout=%0b", andar_atual, to); end
      req = 8'h40; tick(); req = '0;
      req = 8'h22; tick(); req = '0;
      sb_q.push_back(5); sb_q.push_back(6); sb_q.push_back(1);
      checks++;
      if (pending !== 8'h62) begin errors++; $display("FAIL scan_latch pending=%h exp=62", pending); end
      wait_door_at(3'd6, 60, to);
      checks++;
      if (to || pending !== 8'h02) begin errors++; $display("FAIL scan_hold pending=%h exp=02 timeout=%0b", pending, to); end
      to = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (motor_down) begin to = 1'b0; break; end
      end
      checks++;
      if (to || andar_atual !== 3'd6) begin errors++; $display("FAIL scan_reverse floor=%0d exp=6 timeout=%0b", andar_atual, to); end
      wait_idle(100, to);
      checks++;
      if (to || andar_atual !== 3'd1 || pending !== 8'h00) begin
         errors++; $display("FAIL scan_done floor=%0d pending=%h exp=1/00 timeout=%0b", andar_atual, pending, to);
      end
   endtask

   task automatic test_door_recall();
      bit to, motor_seen, door_low;
      req = 8'h04; tick(); req = '0;
      sb_q.push_back(2);
      wait_idle(40, to);
      checks++;
      if (to || andar_atual !== 3'd2) begin errors++; $display("FAIL recall_setup floor=%0d exp=2 timeout=%0b", andar_atual, to); end
      req = 8'h04; tick(); req = '0;
      sb_q.push_back(2);
      checks++;
      if ({door_open, motor_up, motor_down} !== 3'b100) begin
         errors++; $display("FAIL here_open door/up/down=%b exp=100", {door_open, motor_up, motor_down});
      end
      motor_seen = 1'b0; door_low = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         motor_seen |= motor_up | motor_down;
         door_low   |= ~door_open;
      end
      req = 8'h04; tick(); req = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         motor_seen |= motor_up | motor_down;
         door_low   |= ~door_open;
      end
      checks++;
      if (door_low || motor_seen) begin
         errors++; $display("FAIL recall_hold door_dropped=%b motor=%b exp=0/0", door_low, motor_seen);
      end
      tick();
      checks++;
      if (door_open !== 1'b0) begin errors++; $display("FAIL recall_close door=%b exp=0", door_open); end
   endtask

   task automatic test_overload();
      req = 8'h01; tick(); req = '0;
      sb_q.push_back(0);
      person_enter = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      person_enter = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if ({door_open, overload, num_people} !== {1'b1, 1'b1, 4'd11} || andar_atual !== 3'd0) begin
         errors++; $display("FAIL overload_hold door=%b ovl=%b num=%0d floor=%0d exp=1/1/11/0",
                            door_open, overload, num_people, andar_atual);
      end
      person_exit = 1'b1; tick(); person_exit = 1'b0;
      checks++;
      if ({door_open, overload, num_people} !== {1'b1, 1'b0, 4'd10}) begin
         errors++; $display("FAIL overload_clear door=%b ovl=%b num=%0d exp=1/0/10", door_open, overload, num_people);
      end
      tick();
      checks++;
      if ({door_open, busy} !== 2'b00) begin errors++; $display("FAIL overload_close door/busy=%b exp=00", {door_open, busy}); end
   endtask

   task automatic test_saturate();
      person_enter = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      person_enter = 1'b0;
      checks++;
      if (num_people !== 4'd15) begin errors++; $display("FAIL sat_high got=%0d exp=15", num_people); end
      person_enter = 1'b1; person_exit = 1'b1; tick(); person_enter = 1'b0; person_exit = 1'b0;
      checks++;
      if (num_people !== 4'd15) begin errors++; $display("FAIL sat_both got=%0d exp=15", num_people); end
      person_exit = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      person_exit = 1'b0;
      checks++;
      if (num_people !== 4'd10) begin errors++; $display("FAIL count_down got=%0d exp=10", num_people); end
      person_exit = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      person_exit = 1'b0;
      checks++;
      if (num_people !== 4'd0) begin errors++; $display("FAIL sat_low got=%0d exp=0", num_people); end
      person_enter = 1'b1; tick(); person_enter = 1'b0;
      checks++;
      if (num_people !== 4'd1) begin errors++; $display("FAIL count_up got=%0d exp=1", num_people); end
      person_exit = 1'b1; tick(); tick(); person_exit = 1'b0;
      checks++;
      if (num_people !== 4'd0) begin errors++; $display("FAIL exit_at_zero got=%0d exp=0", num_people); end
   endtask

   task automatic test_reset_mid();
      bit to, moved;
      req = 8'h80; tick(); req = '0;
      wait_floor(3'd4, 40, to);
      req = 8'h01; tick(); req = '0;
      checks++;
      if (to || pending !== 8'h81 || motor_up !== 1'b1) begin
         errors++; $display("FAIL mid_setup pending=%h up=%b exp=81/1 timeout=%0b", pending, motor_up, to);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (outv !== 20'h0) begin errors++; $display("FAIL async_reset got=%h exp=%h", outv, 20'h0); end
      tick();
      reset = 1'b0;
      moved = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         moved |= motor_up | motor_down | busy | door_open | (andar_atual != 3'd0);
      end
      checks++;
      if (moved) begin errors++; $display("FAIL post_reset_motion moved=%b exp=0", moved); end
   endtask

   initial begin
      test_reset();
      test_travel_up();
      test_scan();
      test_door_recall();
      test_overload();
      test_saturate();
      test_reset_mid();
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
